// File: rtl/dsp_freezer_pipelined_cfg.sv
// Timing-isolation wrapper for a DSP block: registered input/output buses, valid tracking
// across the DSP latency, and a serial configuration loader with optional input quiescing.
module dsp_freezer_pipelined_cfg #(
   parameter int IN_WIDTH       = 256,
   parameter int OUT_WIDTH      = 256,
   parameter int IN_STAGES      = 1,
   parameter int OUT_STAGES     = 1,
   parameter int DUT_LATENCY    = 4,
   parameter int CFG_BITS       = 32,
   parameter int QUIESCE_ON_CFG = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IN_WIDTH-1:0]  data_in,
   input  logic                 in_valid,
   output logic [IN_WIDTH-1:0]  dut_in,
   input  logic [OUT_WIDTH-1:0] dut_out,
   output logic [OUT_WIDTH-1:0] data_out,
   output logic                 out_valid,
   input  logic [CFG_BITS-1:0]  cfg_word,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   output logic                 cfg_sdo,
   output logic                 cfg_en,
   output logic                 cfg_busy,
   output logic                 cfg_done
);

   localparam int VLAT  = IN_STAGES + DUT_LATENCY + OUT_STAGES;
   localparam int CNT_W = $clog2(CFG_BITS) + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CFG_BITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [CFG_BITS-1:0]  sr;
   logic [CNT_W-1:0]     cnt;
   logic                 quiesce;

   logic [IN_WIDTH-1:0]  in_pipe  [IN_STAGES];
   logic [OUT_WIDTH-1:0] out_pipe [OUT_STAGES];
   logic [VLAT-1:0]      vld_pipe;

   // Whole load window, including the DONE cycle, blocks new data and tokens.
   assign quiesce = (QUIESCE_ON_CFG != 0) && (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < IN_STAGES; i++) in_pipe[i] <= '0;
      end else begin
         in_pipe[0] <= quiesce ? '0 : data_in;
         for (int i = 1; i < IN_STAGES; i++) in_pipe[i] <= in_pipe[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < OUT_STAGES; i++) out_pipe[i] <= '0;
      end else begin
         out_pipe[0] <= dut_out;
         for (int i = 1; i < OUT_STAGES; i++) out_pipe[i] <= out_pipe[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) vld_pipe <= '0;
      else     vld_pipe <= {vld_pipe[VLAT-2:0], in_valid & ~quiesce};
   end

   assign dut_in    = in_pipe[IN_STAGES-1];
   assign data_out  = out_pipe[OUT_STAGES-1];
   assign out_valid = vld_pipe[VLAT-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sr    <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && cfg_valid) begin
            sr  <= cfg_word;
            cnt <= '0;
         end else if (state == SHIFT) begin
            sr  <= sr >> 1;
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      cfg_ready = 1'b0;
      cfg_en    = 1'b0;
      cfg_sdo   = 1'b0;
      cfg_busy  = 1'b0;
      cfg_done  = 1'b0;
      case (state)
         IDLE: begin
            cfg_ready = 1'b1;
            if (cfg_valid) state_nxt = SHIFT;
         end
         SHIFT: begin
            cfg_en   = 1'b1;
            cfg_busy = 1'b1;
            cfg_sdo  = sr[0];
            if (cnt == LAST_BIT) state_nxt = DONE;
         end
         DONE: begin
            cfg_busy  = 1'b1;
            cfg_done  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_dsp_freezer_pipelined_cfg.sv
// Directed bench: four harness configurations with the DSP modelled as a wire loopback.
module tb_dsp_freezer_pipelined_cfg;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] data_in;
   logic        in_valid;

   logic [15:0] a_dut_in, a_data_out, b_dut_in, b_data_out;
   logic [15:0] c_dut_in, c_data_out, d_dut_in, d_data_out;
   logic        a_out_valid, b_out_valid, c_out_valid, d_out_valid;
   logic [7:0]  a_cfg_word;
   logic [3:0]  b_cfg_word, c_cfg_word;
   logic [0:0]  d_cfg_word;
   logic        a_cfg_valid, b_cfg_valid, c_cfg_valid, d_cfg_valid;
   logic        a_cfg_ready, b_cfg_ready, c_cfg_ready, d_cfg_ready;
   logic        a_cfg_sdo, b_cfg_sdo, c_cfg_sdo, d_cfg_sdo;
   logic        a_cfg_en, b_cfg_en, c_cfg_en, d_cfg_en;
   logic        a_cfg_busy, b_cfg_busy, c_cfg_busy, d_cfg_busy;
   logic        a_cfg_done, b_cfg_done, c_cfg_done, d_cfg_done;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dsp_freezer_pipelined_cfg #(.IN_WIDTH(16), .OUT_WIDTH(16), .IN_STAGES(2), .OUT_STAGES(3),
      .DUT_LATENCY(4), .CFG_BITS(8), .QUIESCE_ON_CFG(1)) u_a (
      .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .dut_in(a_dut_in),
      .dut_out(a_dut_in), .data_out(a_data_out), .out_valid(a_out_valid),
      .cfg_word(a_cfg_word), .cfg_valid(a_cfg_valid), .cfg_ready(a_cfg_ready),
      .cfg_sdo(a_cfg_sdo), .cfg_en(a_cfg_en), .cfg_busy(a_cfg_busy), .cfg_done(a_cfg_done));

   dsp_freezer_pipelined_cfg #(.IN_WIDTH(16), .OUT_WIDTH(16), .IN_STAGES(1), .OUT_STAGES(1),
      .DUT_LATENCY(1), .CFG_BITS(4), .QUIESCE_ON_CFG(1)) u_b (
      .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .dut_in(b_dut_in),
      .dut_out(b_dut_in), .data_out(b_data_out), .out_valid(b_out_valid),
      .cfg_word(b_cfg_word), .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready),
      .cfg_sdo(b_cfg_sdo), .cfg_en(b_cfg_en), .cfg_busy(b_cfg_busy), .cfg_done(b_cfg_done));

   dsp_freezer_pipelined_cfg #(.IN_WIDTH(16), .OUT_WIDTH(16), .IN_STAGES(1), .OUT_STAGES(1),
      .DUT_LATENCY(1), .CFG_BITS(4), .QUIESCE_ON_CFG(0)) u_c (
      .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .dut_in(c_dut_in),
      .dut_out(c_dut_in), .data_out(c_data_out), .out_valid(c_out_valid),
      .cfg_word(c_cfg_word), .cfg_valid(c_cfg_valid), .cfg_ready(c_cfg_ready),
      .cfg_sdo(c_cfg_sdo), .cfg_en(c_cfg_en), .cfg_busy(c_cfg_busy), .cfg_done(c_cfg_done));

   dsp_freezer_pipelined_cfg #(.IN_WIDTH(16), .OUT_WIDTH(16), .IN_STAGES(1), .OUT_STAGES(1),
      .DUT_LATENCY(0), .CFG_BITS(1), .QUIESCE_ON_CFG(1)) u_d (
      .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .dut_in(d_dut_in),
      .dut_out(d_dut_in), .data_out(d_data_out), .out_valid(d_out_valid),
      .cfg_word(d_cfg_word), .cfg_valid(d_cfg_valid), .cfg_ready(d_cfg_ready),
      .cfg_sdo(d_cfg_sdo), .cfg_en(d_cfg_en), .cfg_busy(d_cfg_busy), .cfg_done(d_cfg_done));

   // Cycle starts 1 time unit after a rising edge; checks happen at the falling edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [37:0] obs;
      logic [37:0] exp_v;
      exp_v = 38'h1;
      rst = 1'b1; data_in = 16'hFFFF; in_valid = 1'b1;
      a_cfg_valid = 1'b1; b_cfg_valid = 1'b1; c_cfg_valid = 1'b1; d_cfg_valid = 1'b1;
      a_cfg_word = 8'hB4; b_cfg_word = 4'hF; c_cfg_word = 4'hF; d_cfg_word = 1'b1;
      for (int r = 0; r < 2; r++) begin
         next_cycle();
         if (r == 1) begin
            rst = 1'b0; data_in = 16'h0; in_valid = 1'b0;
            b_cfg_valid = 1'b0; c_cfg_valid = 1'b0; d_cfg_valid = 1'b0;
         end
         @(negedge clk);
         obs = {a_dut_in, a_data_out, a_out_valid, a_cfg_sdo, a_cfg_en, a_cfg_busy, a_cfg_done, a_cfg_ready};
         n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL reset_a[%0d] got %h want %h", r, obs, exp_v); end
         obs = {b_dut_in, b_data_out, b_out_valid, b_cfg_sdo, b_cfg_en, b_cfg_busy, b_cfg_done, b_cfg_ready};
         n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL reset_b[%0d] got %h want %h", r, obs, exp_v); end
         obs = {c_dut_in, c_data_out, c_out_valid, c_cfg_sdo, c_cfg_en, c_cfg_busy, c_cfg_done, c_cfg_ready};
         n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL reset_c[%0d] got %h want %h", r, obs, exp_v); end
         obs = {d_dut_in, d_data_out, d_out_valid, d_cfg_sdo, d_cfg_en, d_cfg_busy, d_cfg_done, d_cfg_ready};
         n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL reset_d[%0d] got %h want %h", r, obs, exp_v); end
      end
      // a_cfg_valid still high: first edge after reset release must accept.
      next_cycle();
      a_cfg_valid = 1'b0;
      @(negedge clk);
      n_checks++; if ({a_cfg_en, a_cfg_busy, a_cfg_sdo} !== 3'b110) begin n_fail++; $display("FAIL first_accept en/busy/sdo got %b want 110", {a_cfg_en, a_cfg_busy, a_cfg_sdo}); end
      n_checks++; if (b_cfg_ready !== 1'b1) begin n_fail++; $display("FAIL first_accept b_ready got %b want 1", b_cfg_ready); end
      repeat (12) next_cycle();
   endtask

   task automatic test_data_latency();
      logic [15:0] exp_in, exp_out;
      logic        exp_v;
      for (int c = 0; c < 12; c++) begin
         data_in  = (c == 0) ? 16'h00A5 : (c == 1) ? 16'h03C7 : 16'h0;
         in_valid = (c == 0);
         exp_in  = (c == 2) ? 16'h00A5 : (c == 3) ? 16'h03C7 : 16'h0;
         exp_out = (c == 5) ? 16'h00A5 : (c == 6) ? 16'h03C7 : 16'h0;
         exp_v   = (c == 9);
         @(negedge clk);
         n_checks++; if (a_dut_in !== exp_in) begin n_fail++; $display("FAIL lat_dut_in c%0d got %h want %h", c, a_dut_in, exp_in); end
         n_checks++; if (a_data_out !== exp_out) begin n_fail++; $display("FAIL lat_data_out c%0d got %h want %h", c, a_data_out, exp_out); end
         n_checks++; if (a_out_valid !== exp_v) begin n_fail++; $display("FAIL lat_out_valid c%0d got %b want %b", c, a_out_valid, exp_v); end
         next_cycle();
      end
      data_in = 16'h0; in_valid = 1'b0;
   endtask

   // Checks {en, sdo, done, ready, busy} of instance A for one full 8-bit load of w.
   task automatic test_cfg_shift(input logic [7:0] w);
      logic [4:0] exp_s;
      a_cfg_word = w; a_cfg_valid = 1'b1;
      @(negedge clk);
      n_checks++; if (a_cfg_ready !== 1'b1) begin n_fail++; $display("FAIL cfg_ready_before got %b want 1", a_cfg_ready); end
      next_cycle();
      a_cfg_word = ~w;
      for (int c = 1; c <= 10; c++) begin
         a_cfg_valid = (c >= 3 && c <= 5);
         if (c <= 8)       exp_s = {1'b1, w[c-1], 1'b0, 1'b0, 1'b1};
         else if (c == 9)  exp_s = 5'b00101;
         else              exp_s = 5'b00010;
         @(negedge clk);
         n_checks++;
         if ({a_cfg_en, a_cfg_sdo, a_cfg_done, a_cfg_ready, a_cfg_busy} !== exp_s) begin
            n_fail++;
            $display("FAIL cfg_shift w=%h c%0d en/sdo/done/ready/busy got %b want %b", w, c, {a_cfg_en, a_cfg_sdo, a_cfg_done, a_cfg_ready, a_cfg_busy}, exp_s);
         end
         next_cycle();
      end
      a_cfg_valid = 1'b0;
   endtask

   task automatic test_quiesce();
      logic [15:0] exp_in, exp_out;
      logic        exp_v;
      data_in = 16'h003C; in_valid = 1'b1;
      repeat (3) next_cycle();
      for (int c = 0; c < 12; c++) begin
         b_cfg_valid = (c == 0); c_cfg_valid = (c == 0);
         b_cfg_word = 4'hA; c_cfg_word = 4'hA;
         exp_in  = (c >= 2 && c <= 6) ? 16'h0 : 16'h003C;
         exp_out = (c >= 3 && c <= 7) ? 16'h0 : 16'h003C;
         exp_v   = !(c >= 4 && c <= 8);
         @(negedge clk);
         n_checks++; if (b_dut_in !== exp_in) begin n_fail++; $display("FAIL q_b_dut_in c%0d got %h want %h", c, b_dut_in, exp_in); end
         n_checks++; if (b_data_out !== exp_out) begin n_fail++; $display("FAIL q_b_data_out c%0d got %h want %h", c, b_data_out, exp_out); end
         n_checks++; if (b_out_valid !== exp_v) begin n_fail++; $display("FAIL q_b_out_valid c%0d got %b want %b", c, b_out_valid, exp_v); end
         n_checks++; if (b_cfg_done !== (c == 5)) begin n_fail++; $display("FAIL q_b_done c%0d got %b want %b", c, b_cfg_done, (c == 5)); end
         n_checks++; if ({c_dut_in, c_out_valid} !== {16'h003C, 1'b1}) begin n_fail++; $display("FAIL noq_c c%0d got %h/%b want 003c/1", c, c_dut_in, c_out_valid); end
         next_cycle();
      end
      b_cfg_valid = 1'b0; c_cfg_valid = 1'b0;
      data_in = 16'h0; in_valid = 1'b0;
      repeat (4) next_cycle();
   endtask

   task automatic test_back_to_back();
      logic [2:0] bits;
      logic [4:0] exp_s;
      int ph;
      bits = 3'b101;
      d_cfg_valid = 1'b1;
      for (int c = 0; c < 9; c++) begin
         ph = c % 3;
         d_cfg_word = (ph == 0) ? bits[c/3] : ~bits[c/3];
         exp_s = {ph == 1, (ph == 1) ? bits[c/3] : 1'b0, ph == 2, ph == 0, ph != 0};
         @(negedge clk);
         n_checks++;
         if ({d_cfg_en, d_cfg_sdo, d_cfg_done, d_cfg_ready, d_cfg_busy} !== exp_s) begin
            n_fail++;
            $display("FAIL b2b c%0d en/sdo/done/ready/busy got %b want %b", c, {d_cfg_en, d_cfg_sdo, d_cfg_done, d_cfg_ready, d_cfg_busy}, exp_s);
         end
         next_cycle();
      end
      d_cfg_valid = 1'b0;
      next_cycle();
      @(negedge clk);
      n_checks++; if ({d_cfg_busy, d_cfg_ready} !== 2'b01) begin n_fail++; $display("FAIL b2b_stop busy/ready got %b want 01", {d_cfg_busy, d_cfg_ready}); end
      next_cycle();
   endtask

   task automatic test_reset_abort();
      logic [7:0] w;
      logic [3:0] exp_s;
      w = 8'hC3;
      a_cfg_word = w; a_cfg_valid = 1'b1;
      next_cycle();
      a_cfg_valid = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         rst = (c == 3);
         exp_s = (c <= 3) ? {1'b1, w[c-1], 1'b0, 1'b0} : 4'b0001;
         @(negedge clk);
         n_checks++;
         if ({a_cfg_en, a_cfg_sdo, a_cfg_done, a_cfg_ready} !== exp_s) begin
            n_fail++;
            $display("FAIL abort c%0d en/sdo/done/ready got %b want %b", c, {a_cfg_en, a_cfg_sdo, a_cfg_done, a_cfg_ready}, exp_s);
         end
         next_cycle();
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_data_latency();
      test_cfg_shift(8'hB4);
      test_quiesce();
      test_back_to_back();
      test_reset_abort();
      test_cfg_shift(8'h5A);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dsp_freezer_pipelined_cfg.md
# dsp_freezer_pipelined_cfg

- Parametrised timing-isolation and configuration harness placed around any DSP block variant under synthesis or timing study.
- Registers the flattened DSP input and output buses through a configurable number of stages.
- Tracks a valid token through the whole path, including the DSP's own latency.
- Owns the serial configuration chain: accepts a parallel word via valid/ready and shifts it into the DSP one bit per cycle, optionally quiescing data inputs during the load.

## Interface
Parameters:
- IN_WIDTH, 256, width of flattened DSP input bus (A, B, C, D, modes, cascades).
- OUT_WIDTH, 256, width of flattened DSP output bus.
- IN_STAGES, 1, input register depth, legal 1..4.
- OUT_STAGES, 1, output register depth, legal 1..4.
- DUT_LATENCY, 4, DSP internal latency in cycles, used only for valid tracking; legal 0..15.
- CFG_BITS, 32, configuration chain length, legal 1..1024.
- QUIESCE_ON_CFG, 1, when 1 data inputs are zeroed while a configuration load is in progress.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  IN_WIDTH  user-side DSP inputs.
- in_valid  in  1  qualifies data_in.
- dut_in  out  IN_WIDTH  registered inputs to the DSP.
- dut_out  in  OUT_WIDTH  raw DSP outputs.
- data_out  out  OUT_WIDTH  registered DSP outputs.
- out_valid  out  1  in_valid delayed by the total path latency.
- cfg_word  in  CFG_BITS  configuration word, bit 0 shifted first.
- cfg_valid  in  1  request to load cfg_word.
- cfg_ready  out  1  high only in IDLE.
- cfg_sdo  out  1  serial config bit to DSP configuration_input.
- cfg_en  out  1  to DSP configuration_enable; high exactly while cfg_sdo carries a valid bit.
- cfg_busy  out  1  high in SHIFT and DONE.
- cfg_done  out  1  one-cycle pulse at load completion.

## Operation
- Input path: shift chain of IN_STAGES registers from data_in to dut_in. The stage-1 load value is data_in, or zero when QUIESCE_ON_CFG=1 and state≠IDLE.
- Output path: shift chain of OUT_STAGES registers from dut_out to data_out. It is never quiesced.
- Valid path: shift register of depth IN_STAGES+DUT_LATENCY+OUT_STAGES fed by in_valid. The fed value is forced to 0 under the same quiesce condition as the data path.
- Config FSM states:
  - IDLE: cfg_ready=1. cfg_valid&cfg_ready captures cfg_word into shift register sr, clears bit counter cnt, and moves to SHIFT.
  - SHIFT: cfg_en=1, cfg_sdo=sr[0]. Each cycle sr shifts right (zero fill) and cnt increments. When cnt==CFG_BITS-1, move to DONE.
  - DONE: cfg_done=1, cfg_en=0, then IDLE.
- cfg_valid is ignored outside IDLE, and cfg_word is only sampled on the accept edge.
- cnt is $clog2(CFG_BITS)+1 bits wide, so CFG_BITS=1 is a legal single-bit load.

## Timing
- Reset (rst high at an edge):
  - All pipeline, valid, sr and cnt registers clear.
  - State goes to IDLE.
  - Outputs after that edge: dut_in=0, data_out=0, out_valid=0, cfg_sdo=0, cfg_en=0, cfg_busy=0, cfg_done=0, cfg_ready=1.
  - rst dominates all other inputs in the same cycle.
- Reset mid-SHIFT aborts the load:
  - cfg_en=0 from the next cycle.
  - No cfg_done pulse.
  - The DSP chain is left partially loaded; software must reload.
- data_in sampled at edge k appears on dut_in after edge k+IN_STAGES-1, i.e. visible IN_STAGES cycles after presentation.
- dut_out to data_out takes OUT_STAGES cycles.
- out_valid follows in_valid by IN_STAGES+DUT_LATENCY+OUT_STAGES cycles.
- Config load accepted at edge k:
  - Bit i is on cfg_sdo with cfg_en=1 in cycle k+1+i, for i=0..CFG_BITS-1.
  - cfg_done=1 in cycle k+CFG_BITS+1.
  - cfg_ready rises in cycle k+CFG_BITS+2; earliest next accept is at that cycle's edge.
- Quiesce window covers cycles k+1 through k+CFG_BITS+1. Stage 1 loads zero there, and in_valid presented in that window is dropped, not stalled.
- A handshake in the same cycle as rst is not accepted.

## Test plan
- Reset: drive rst for 2 cycles with data_in=all-ones, in_valid=1, cfg_valid=1 -> all outputs 0, cfg_ready=1, no load starts. First load accepts at the first edge after rst falls.
- Data latency, IN_STAGES=2, OUT_STAGES=3, DUT_LATENCY=4, loopback dut_out=dut_in[OUT_WIDTH-1:0]:
  - Pulse in_valid with data_in=0xA5 at cycle 0.
  - Required: dut_in=0xA5 at cycle 2, data_out=0xA5 at cycle 5.
  - Required: out_valid=1 at cycle 9 only.
- Config shift, CFG_BITS=8, cfg_word=0xB4 accepted at cycle 0:
  - cfg_sdo over cycles 1..8 = 0,0,1,0,1,1,0,1 with cfg_en=1 throughout.
  - cfg_done at cycle 9; cfg_ready=1 at cycle 10.
- Quiesce, QUIESCE_ON_CFG=1, CFG_BITS=4:
  - Streaming in_valid=1, data_in=0x3C during a load accepted at cycle 0 -> stage-1 holds zero and valid tokens are dropped for cycles 1..5.
  - Data resumes at cycle 6.
  - With QUIESCE_ON_CFG=0 there is no gap.
- Back-to-back loads: cfg_valid held high with CFG_BITS=1 -> accepts at cycles 0, 3, 6, and cfg_sdo pulses once per load.
- Reset abort: rst asserted at cycle 3 of an 8-bit load -> cfg_en=0 from cycle 4, no cfg_done, cfg_ready=1; a fresh load then completes normally.
